branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences control-flow redirects for the 8-bit pipelined core.
- Consumes the EX-stage equality-compare result (taken) plus the branch/jump decode. It then registers the redirect, drives the PC-load handshake to the fetch unit, and issues the pipeline flush pulses.
- Sits between the EX-stage compare, the hazard unit (stall_in) and the IF/ID, ID/EX and EX/MEM pipeline registers.

Parameters:
- PC_W, 8, width of PC and branch target.
- CNT_W, 16, width of performance counters (used only with the optional feature).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ex_valid  input  1  EX stage holds a valid, non-bubble instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_is_jump  input  1  EX instruction is an unconditional jump.
- ex_taken  input  1  compare result for EX operands (1 = equal, take the branch).
- ex_target  input  PC_W  resolved target PC of the EX instruction.
- stall_in  input  1  hazard unit freezes the EX stage this cycle.
- pc_ack  input  1  fetch unit accepted pc_load this cycle.
- pc_load  output  1  request fetch unit to load pc_target.
- pc_target  output  PC_W  redirect address, stable while pc_load=1.
- flush_if_id  output  1  clear IF/ID register at the next edge.
- flush_id_ex  output  1  clear ID/EX register at the next edge.
- flush_ex_mem  output  1  clear EX/MEM register at the next edge.
- busy  output  1  redirect in progress (state != IDLE).
- perf_branches  output  CNT_W  total resolved branches/jumps.
- perf_taken  output  CNT_W  total redirects.
- perf_wait  output  CNT_W  cycles spent waiting for pc_ack.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; pc_target=0; pc_load, flush_*, busy=0; perf_* =0. Reset asserted mid-redirect abandons it immediately.
- Accept condition (IDLE only): ex_valid & !stall_in & (ex_is_jump | (ex_is_branch & ex_taken)).
- When stall_in=1, nothing is accepted that cycle. The same instruction is re-evaluated the next cycle.
- States:
  - IDLE: on accept at edge T, latch pc_target<=ex_target, go to REDIRECT; the flag first<=1.
  - REDIRECT: pc_load=1, busy=1, flush_if_id=1, flush_id_ex=1. flush_ex_mem=1 only while first=1, i.e. the first REDIRECT cycle, which kills the wrong-path instruction leaving EX. first clears after that cycle.
  - If pc_ack=1 in REDIRECT, go to IDLE at the next edge. The flushes remain asserted in that ack cycle, so the stale fetch is discarded.
- Redirect latency: accept at cycle T, then pc_load and flushes at T+1. The earliest correct-path fetch is at T+2 when pc_ack=1 at T+1.
- While in REDIRECT, all ex_* inputs and stall_in are ignored, because only wrong-path instructions or bubbles are in EX. pc_target holds constant.
- Not-taken branch (ex_is_branch & !ex_taken): no redirect, no flush, state stays IDLE.
- ex_is_branch and ex_is_jump both 1: treated as a jump (taken).
- ex_valid=0: all other ex_* inputs are ignored.
- pc_ack while in IDLE: ignored.
- The REDIRECT wait is unbounded; state holds until pc_ack.

Optional Feature:
- Macro: BRANCH_REDIRECT_PERF_EN.
- Defined:
  - perf_branches increments on each cycle with ex_valid & !stall_in & (ex_is_branch|ex_is_jump) in IDLE.
  - perf_taken increments on each accept.
  - perf_wait increments on each REDIRECT cycle with pc_ack=0.
  - All counters saturate at all-ones (no wrap).
- Undefined: perf_* ports remain and are tied to 0; no counter flops are synthesised.

Test Plan:
- Taken branch: ex_valid=1, ex_is_branch=1, ex_taken=1, ex_target=0x3C, pc_ack=1 at T+1 -> at T+1 pc_load=1, pc_target=0x3C, all three flushes=1. At T+2 busy=0 and flushes=0.
- Not-taken: ex_is_branch=1, ex_taken=0 -> pc_load and flushes stay 0 for all cycles. With macro, perf_branches=1 and perf_taken=0.
- Stall then accept: jump with target 0x10 and stall_in=1 for 2 cycles, then 0 -> no pc_load during the stall; pc_load=1 with target 0x10 exactly one cycle after stall_in drops.
- Slow fetch: accept target 0xF0, pc_ack low for 3 cycles then high -> pc_load, flush_if_id and flush_id_ex held for 4 cycles, flush_ex_mem only in the first. A second taken branch presented during the wait is ignored. With macro, perf_wait=3.
- Async reset mid-REDIRECT: rst_n low for half a cycle while pc_load=1 -> outputs drop to 0 immediately. After release, a new accept behaves normally.
- Saturation (macro, CNT_W=4): 20 taken jumps -> perf_taken=15.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Redirect-controller bus: EX-stage resolve inputs, hazard stall, fetch PC-load handshake,
// pipeline flush strobes and performance counters.
interface branch_redirect_ctrl_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
);
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic             ex_taken;
  logic [PC_W-1:0]  ex_target;
  logic             stall_in;
  logic             pc_ack;
  logic             pc_load;
  logic [PC_W-1:0]  pc_target;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic             busy;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_taken;
  logic [CNT_W-1:0] perf_wait;

  // Pipeline/fetch side.
  modport master (
    output ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_target, stall_in, pc_ack,
    input  pc_load, pc_target, flush_if_id, flush_id_ex, flush_ex_mem, busy,
           perf_branches, perf_taken, perf_wait
  );

  // Redirect controller side.
  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_target, stall_in, pc_ack,
    output pc_load, pc_target, flush_if_id, flush_id_ex, flush_ex_mem, busy,
           perf_branches, perf_taken, perf_wait
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Control-flow redirect sequencer: registers taken branches/jumps, drives the PC-load
// handshake and pipeline flushes. Define BRANCH_REDIRECT_PERF_EN for saturating perf counters.
module branch_redirect_ctrl #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_redirect_ctrl_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_target_q;
  logic            pc_load_q;
  logic            busy_q;
  logic            flush_if_id_q;
  logic            flush_id_ex_q;
  logic            flush_ex_mem_q;

  logic resolve_c;
  logic accept_c;

  assign resolve_c = bus.ex_valid & ~bus.stall_in & (bus.ex_is_branch | bus.ex_is_jump);
  assign accept_c  = resolve_c & (bus.ex_is_jump | bus.ex_taken);

  // flush_ex_mem doubles as the first-REDIRECT-cycle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_target_q    <= '0;
      pc_load_q      <= 1'b0;
      busy_q         <= 1'b0;
      flush_if_id_q  <= 1'b0;
      flush_id_ex_q  <= 1'b0;
      flush_ex_mem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q        <= REDIRECT;
            pc_target_q    <= bus.ex_target;
            pc_load_q      <= 1'b1;
            busy_q         <= 1'b1;
            flush_if_id_q  <= 1'b1;
            flush_id_ex_q  <= 1'b1;
            flush_ex_mem_q <= 1'b1;
          end
        end
        REDIRECT: begin
          flush_ex_mem_q <= 1'b0;
          if (bus.pc_ack) begin
            state_q       <= IDLE;
            pc_load_q     <= 1'b0;
            busy_q        <= 1'b0;
            flush_if_id_q <= 1'b0;
            flush_id_ex_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= IDLE;
          pc_load_q      <= 1'b0;
          busy_q         <= 1'b0;
          flush_if_id_q  <= 1'b0;
          flush_id_ex_q  <= 1'b0;
          flush_ex_mem_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_load      = pc_load_q;
  assign bus.pc_target    = pc_target_q;
  assign bus.busy         = busy_q;
  assign bus.flush_if_id  = flush_if_id_q;
  assign bus.flush_id_ex  = flush_id_ex_q;
  assign bus.flush_ex_mem = flush_ex_mem_q;

`ifdef BRANCH_REDIRECT_PERF_EN
  logic [CNT_W-1:0] perf_branches_q;
  logic [CNT_W-1:0] perf_taken_q;
  logic [CNT_W-1:0] perf_wait_q;
  logic             in_idle_c;
  logic             wait_c;

  assign in_idle_c = (state_q == IDLE);
  assign wait_c    = (state_q == REDIRECT) & ~bus.pc_ack;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q <= '0;
      perf_taken_q    <= '0;
      perf_wait_q     <= '0;
    end else begin
      if (in_idle_c && resolve_c && (perf_branches_q != '1))
        perf_branches_q <= perf_branches_q + CNT_W'(1);
      if (in_idle_c && accept_c && (perf_taken_q != '1))
        perf_taken_q <= perf_taken_q + CNT_W'(1);
      if (wait_c && (perf_wait_q != '1))
        perf_wait_q <= perf_wait_q + CNT_W'(1);
    end
  end

  assign bus.perf_branches = perf_branches_q;
  assign bus.perf_taken    = perf_taken_q;
  assign bus.perf_wait     = perf_wait_q;
`else
  assign bus.perf_branches = CNT_W'(0);
  assign bus.perf_taken    = CNT_W'(0);
  assign bus.perf_wait     = CNT_W'(0);
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_branch_redirect_ctrl;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  branch_redirect_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_redirect_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: a redirect is "in flight" from accept until the acked cycle.
  bit              m_active;
  int              m_age;
  logic [PC_W-1:0] m_target;
  int              m_br, m_tk, m_wt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_age = 0; m_target = '0;
      m_br = 0; m_tk = 0; m_wt = 0;
    end else if (m_active) begin
      if (bus.pc_ack) m_active = 0;
      else begin
        m_wt++;
        m_age++;
      end
    end else if (bus.ex_valid && !bus.stall_in) begin
      if (bus.ex_is_branch || bus.ex_is_jump) m_br++;
      if (bus.ex_is_jump || (bus.ex_is_branch && bus.ex_taken)) begin
        m_active = 1;
        m_age    = 0;
        m_target = bus.ex_target;
        m_tk++;
      end
    end
  end

  function automatic int perf_exp(input int raw);
`ifdef BRANCH_REDIRECT_PERF_EN
    return (raw > SAT) ? SAT : raw;
`else
    return 0 * raw;
`endif
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("pc_load",       32'(bus.pc_load),       32'(m_active));
    check("busy",          32'(bus.busy),          32'(m_active));
    check("flush_if_id",   32'(bus.flush_if_id),   32'(m_active));
    check("flush_id_ex",   32'(bus.flush_id_ex),   32'(m_active));
    check("flush_ex_mem",  32'(bus.flush_ex_mem),  32'(m_active && (m_age == 0)));
    check("pc_target",     32'(bus.pc_target),     32'(m_target));
    check("perf_branches", 32'(bus.perf_branches), 32'(perf_exp(m_br)));
    check("perf_taken",    32'(bus.perf_taken),    32'(perf_exp(m_tk)));
    check("perf_wait",     32'(bus.perf_wait),     32'(perf_exp(m_wt)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit br, input bit jp, input bit tk,
                       input logic [PC_W-1:0] tgt, input bit st, input bit ack);
    bus.ex_valid     = v;
    bus.ex_is_branch = br;
    bus.ex_is_jump   = jp;
    bus.ex_taken     = tk;
    bus.ex_target    = tgt;
    bus.stall_in     = st;
    bus.pc_ack       = ack;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    tick(); tick();
    check("reset_pc_load", 32'(bus.pc_load), 32'd0);
    check("reset_target",  32'(bus.pc_target), 32'd0);
    rst_n = 1'b1;
    tick();

    // Taken branch to 0x3C, acked in the first REDIRECT cycle.
    drive(1, 1, 0, 1, 8'h3C, 0, 0);
    tick();
    drive(0, 0, 0, 0, 8'h00, 0, 1);
    check("tb_pc_load",   32'(bus.pc_load),      32'd1);
    check("tb_target",    32'(bus.pc_target),    32'h3C);
    check("tb_ex_mem",    32'(bus.flush_ex_mem), 32'd1);
    check("tb_if_id",     32'(bus.flush_if_id),  32'd1);
    tick();
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    check("tb_busy_done", 32'(bus.busy),         32'd0);
    check("tb_flush_done",32'(bus.flush_id_ex),  32'd0);

    // Not-taken branch.
    drive(1, 1, 0, 0, 8'h99, 0, 0);
    tick();
    check("nt_pc_load", 32'(bus.pc_load), 32'd0);
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    tick();

    // Jump held off by a 2-cycle stall.
    drive(1, 0, 1, 0, 8'h10, 1, 0);
    tick();
    check("st_pc_load1", 32'(bus.pc_load), 32'd0);
    tick();
    check("st_pc_load2", 32'(bus.pc_load), 32'd0);
    bus.stall_in = 1'b0;
    tick();
    check("st_pc_load3", 32'(bus.pc_load),   32'd1);
    check("st_target",   32'(bus.pc_target), 32'h10);
    drive(0, 0, 0, 0, 8'h00, 0, 1);
    tick();
    bus.pc_ack = 1'b0;

    // Slow fetch with a competing branch presented during the wait.
    drive(1, 0, 1, 0, 8'hF0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 8'h55, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sf_pc_load", 32'(bus.pc_load),      32'd1);
      check("sf_target",  32'(bus.pc_target),    32'hF0);
      check("sf_ex_mem",  32'(bus.flush_ex_mem), 32'd0);
    end
    drive(0, 0, 0, 0, 8'h00, 0, 1);
    tick();
    check("sf_done", 32'(bus.pc_load), 32'd0);
    bus.pc_ack = 1'b0;

    // Asynchronous reset in the middle of a redirect.
    drive(1, 0, 1, 0, 8'h77, 0, 0);
    tick();
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    check("ar_pc_load_pre", 32'(bus.pc_load), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_pc_load", 32'(bus.pc_load),   32'd0);
    check("ar_busy",    32'(bus.busy),      32'd0);
    check("ar_target",  32'(bus.pc_target), 32'd0);
    #4 rst_n = 1'b1;
    tick();
    drive(1, 0, 1, 0, 8'h21, 0, 0);
    tick();
    drive(0, 0, 0, 0, 8'h00, 0, 1);
    check("ar_new_load",   32'(bus.pc_load),   32'd1);
    check("ar_new_target", 32'(bus.pc_target), 32'h21);
    tick();
    bus.pc_ack = 1'b0;

    // 20 back-to-back taken jumps, each acked immediately (drives saturation when enabled).
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, PC_W'(i), 0, 0);
      tick();
      drive(0, 0, 0, 0, 8'h00, 0, 1);
      tick();
    end
`ifdef BRANCH_REDIRECT_PERF_EN
    check("sat_perf_taken", 32'(bus.perf_taken), 32'd15);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom), PC_W'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 4));
      tick();
    end
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
